// File: rtl/matmul_apb_arbiter.sv
// Two-master round-robin APB arbiter in front of the matmul slave port.
// Define MATMUL_ARB_LOCK_EN to keep the bus with the master that started a job until busy falls.
module matmul_apb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned MAX_DIM    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_psel_i,
  input  logic                  m0_penable_i,
  input  logic                  m0_pwrite_i,
  input  logic [ADDR_WIDTH-1:0] m0_paddr_i,
  input  logic [BUS_WIDTH-1:0]  m0_pwdata_i,
  input  logic [MAX_DIM-1:0]    m0_pstrb_i,
  output logic [BUS_WIDTH-1:0]  m0_prdata_o,
  output logic                  m0_pready_o,
  output logic                  m0_pslverr_o,
  input  logic                  m1_psel_i,
  input  logic                  m1_penable_i,
  input  logic                  m1_pwrite_i,
  input  logic [ADDR_WIDTH-1:0] m1_paddr_i,
  input  logic [BUS_WIDTH-1:0]  m1_pwdata_i,
  input  logic [MAX_DIM-1:0]    m1_pstrb_i,
  output logic [BUS_WIDTH-1:0]  m1_prdata_o,
  output logic                  m1_pready_o,
  output logic                  m1_pslverr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic                  busy_i,
  output logic                  grant_o,
  output logic                  lock_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  grant_q, grant_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic [MAX_DIM-1:0]    strb_q, strb_d;
  logic [1:0]            eligible;
  logic [1:0]            req;
  logic                  win;
  logic                  xfer_done;

  assign xfer_done = (state_q == ACCESS) && pready_i;

`ifdef MATMUL_ARB_LOCK_EN
  logic lock_q, owner_q, busy_seen_q;
  logic job_start;
  logic unused;

  // A successful write setting CONTROL.start opens (or re-arms) the job lock.
  assign job_start = xfer_done && write_q && (addr_q[4:0] == 5'd0) && wdata_q[0] && !pslverr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q      <= 1'b0;
      owner_q     <= 1'b0;
      busy_seen_q <= 1'b0;
    end else if (job_start) begin
      lock_q      <= 1'b1;
      owner_q     <= grant_q;
      busy_seen_q <= 1'b0;
    end else if (lock_q) begin
      if (busy_seen_q && !busy_i) begin
        lock_q      <= 1'b0;
        busy_seen_q <= 1'b0;
      end else if (busy_i) begin
        busy_seen_q <= 1'b1;
      end
    end
  end

  assign lock_o   = lock_q;
  assign eligible = lock_q ? (owner_q ? 2'b10 : 2'b01) : 2'b11;
  assign unused   = ^{m0_penable_i, m1_penable_i};
`else
  logic unused;

  assign lock_o   = 1'b0;
  assign eligible = 2'b11;
  assign unused   = ^{m0_penable_i, m1_penable_i, busy_i};
`endif

  // Round-robin pick: on contention the master that was not served last wins.
  assign req = {m1_psel_i, m0_psel_i} & eligible;
  assign win = (req == 2'b11) ? ~prio_q : req[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b1;
      grant_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_d = win;
          write_d = win ? m1_pwrite_i : m0_pwrite_i;
          addr_d  = win ? m1_paddr_i  : m0_paddr_i;
          wdata_d = win ? m1_pwdata_i : m0_pwdata_i;
          strb_d  = win ? m1_pstrb_i  : m0_pstrb_i;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          state_d = IDLE;
          prio_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream fields are only visible while a transfer is in flight.
  assign psel_o    = (state_q != IDLE);
  assign penable_o = (state_q == ACCESS);
  assign pwrite_o  = psel_o & write_q;
  assign paddr_o   = psel_o ? addr_q  : '0;
  assign pwdata_o  = psel_o ? wdata_q : '0;
  assign pstrb_o   = psel_o ? strb_q  : '0;
  assign grant_o   = grant_q;

  // Completion is passed straight through to the granted master only.
  assign m0_pready_o  = xfer_done && !grant_q;
  assign m1_pready_o  = xfer_done &&  grant_q;
  assign m0_prdata_o  = m0_pready_o ? prdata_i : '0;
  assign m1_prdata_o  = m1_pready_o ? prdata_i : '0;
  assign m0_pslverr_o = m0_pready_o & pslverr_i;
  assign m1_pslverr_o = m1_pready_o & pslverr_i;

endmodule
